// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: shared FSM states, prefix defaults and key event type for ps2_kbd_ctrl
package ps2_kbd_pkg;
  typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;
  localparam logic [7:0] BREAK_CODE_DEF = 8'hF0;
  localparam logic [7:0] EXT_CODE_DEF = 8'hE0;
  typedef struct packed {
    logic [7:0] code;
    logic brk;
    logic ext;
  } key_evt_t;
endpackage

// File: rtl/ps2_kbd_decode.sv
// ps2_kbd_decode: scan-code set 2 prefix tracking; forms one event per non-prefix byte
module ps2_kbd_decode
  import ps2_kbd_pkg::*;
#(
  parameter logic [7:0] BREAK_CODE = BREAK_CODE_DEF,
  parameter logic [7:0] EXT_CODE = EXT_CODE_DEF
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       cap,
  input  logic [7:0] data,
  output key_evt_t   evt,
  output logic       evt_ok
);
  logic ext_flag, brk_flag, is_ext, is_brk;
  assign is_ext = data == EXT_CODE;
  assign is_brk = data == BREAK_CODE;
  assign evt_ok = cap && !is_ext && !is_brk;
  assign evt = {data, brk_flag, ext_flag};
  // a prefix keeps the other prefix, so E0 F0 and F0 E0 both accumulate
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (cap) begin
      ext_flag <= is_ext | (ext_flag & is_brk);
      brk_flag <= is_brk | (brk_flag & is_ext);
    end
endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: drains the ps2_keyboard FIFO, emits key events, tracks held key and press count.
// Optional PS2_KBD_REPEAT_FILTER_EN drops typematic repeats of the held key.
module ps2_kbd_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter logic [7:0] BREAK_CODE = BREAK_CODE_DEF,
  parameter logic [7:0] EXT_CODE = EXT_CODE_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  input  logic             kbd_overflow,
  output logic             kbd_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_break,
  output logic             evt_ext,
  output logic             key_down,
  output logic [7:0]       cur_code,
  output logic             cur_ext,
  output logic [CNT_W-1:0] press_cnt,
  input  logic             ovf_clr,
  output logic             ovf_sticky
);
  state_t state, next;
  key_evt_t d_evt;
  logic d_ok, cap, emit, held_match;
  assign cap = state == IDLE && kbd_ready && (!evt_valid || evt_ready);
  always_comb begin
    next = state;
    kbd_nextdata_n = 1'b1;
    case (state)
      IDLE: next = cap ? POP : IDLE;
      POP: begin
        next = SETTLE;
        kbd_nextdata_n = 1'b0;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) state <= IDLE;
    else state <= next;
  ps2_kbd_decode #(.BREAK_CODE(BREAK_CODE), .EXT_CODE(EXT_CODE)) u_dec (
    .clk(clk), .clrn(clrn), .cap(cap), .data(kbd_data), .evt(d_evt), .evt_ok(d_ok)
  );
  assign held_match = key_down && cur_code == d_evt.code && cur_ext == d_evt.ext;
`ifdef PS2_KBD_REPEAT_FILTER_EN
  assign emit = d_ok && (d_evt.brk || !held_match);
`else
  assign emit = d_ok;
`endif
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      evt_valid <= 1'b0;
      evt_code <= 8'h00;
      evt_break <= 1'b0;
      evt_ext <= 1'b0;
      key_down <= 1'b0;
      cur_code <= 8'h00;
      cur_ext <= 1'b0;
      press_cnt <= '0;
    end else begin
      if (emit) begin
        evt_valid <= 1'b1;
        evt_code <= d_evt.code;
        evt_break <= d_evt.brk;
        evt_ext <= d_evt.ext;
        if (!d_evt.brk) begin
          key_down <= 1'b1;
          cur_code <= d_evt.code;
          cur_ext <= d_evt.ext;
          press_cnt <= press_cnt + 1'b1;
        end else if (held_match) key_down <= 1'b0;
      end else if (evt_valid && evt_ready) evt_valid <= 1'b0;
    end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) ovf_sticky <= 1'b0;
    else ovf_sticky <= kbd_overflow | (ovf_sticky & ~ovf_clr);
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: scoreboard bench with a byte-stream reference model and a FIFO model of ps2_keyboard
module tb_ps2_kbd_ctrl;
  logic clk = 0, clrn = 1;
  logic [7:0] kbd_data = 0;
  logic kbd_ready = 0, kbd_overflow = 0, kbd_nextdata_n;
  logic evt_valid, evt_ready = 0, evt_break, evt_ext, key_down, cur_ext, ovf_sticky, ovf_clr = 0;
  logic [7:0] evt_code, cur_code, press_cnt;
  int n_chk = 0, n_err = 0, pops = 0, n_evt = 0, rdy_mode = 0;
  logic prev_low = 0, stalled = 0;
  logic [9:0] held_evt;
  typedef struct {
    logic [7:0] code;
    logic brk, ext, down;
    logic [7:0] cc;
    logic ce;
    logic [7:0] cnt;
  } exp_t;
  exp_t exp_q[$];
  logic [7:0] fifo[$];
  logic m_ext = 0, m_brk = 0, m_down = 0, m_ce = 0;
  logic [7:0] m_cc = 0, m_cnt = 0;
`ifdef PS2_KBD_REPEAT_FILTER_EN
  localparam bit FILT = 1;
`else
  localparam bit FILT = 0;
`endif

  always #5 clk = ~clk;

  ps2_kbd_ctrl dut (
    .clk(clk), .clrn(clrn), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .kbd_overflow(kbd_overflow), .kbd_nextdata_n(kbd_nextdata_n),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_break(evt_break), .evt_ext(evt_ext), .key_down(key_down),
    .cur_code(cur_code), .cur_ext(cur_ext), .press_cnt(press_cnt),
    .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky)
  );

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // reference: interpret the byte stream as scan-code set 2
  task automatic send(logic [7:0] b);
    bit drop;
    drop = 0;
    fifo.push_back(b);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (FILT) drop = !m_brk && m_down && m_cc == b && m_ce == m_ext;
      if (!drop) begin
        if (!m_brk) begin
          m_down = 1; m_cc = b; m_ce = m_ext; m_cnt = m_cnt + 1;
        end else if (m_down && m_cc == b && m_ce == m_ext) m_down = 0;
        exp_q.push_back('{b, m_brk, m_ext, m_down, m_cc, m_ce, m_cnt});
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((fifo.size() > 0 || exp_q.size() > 0 || kbd_ready) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk("drain_timeout", 32'(t < 3000), 1);
  endtask

  task automatic chk_reset_vals(string name);
    chk(name, {kbd_nextdata_n, evt_valid, evt_code, evt_break, evt_ext, key_down,
               cur_code, cur_ext, press_cnt, ovf_sticky}, {1'b1, 30'b0});
  endtask

  // ps2_keyboard FIFO model: pop on low strobe, head/ready update after the edge
  always @(posedge clk) begin
    if (!kbd_nextdata_n) begin
      pops++;
      chk("pop_nonempty", 32'(fifo.size() > 0), 1);
      chk("single_pop", 32'(prev_low), 0);
      if (fifo.size() > 0) void'(fifo.pop_front());
    end
    prev_low = !kbd_nextdata_n;
    kbd_ready <= fifo.size() > 0;
    kbd_data <= fifo.size() > 0 ? fifo[0] : 8'h00;
  end

  // monitor: accept decided here takes effect on the following posedge
  always @(negedge clk) begin
    if (clrn && stalled) chk("stall_hold", {evt_valid, evt_code, evt_break, evt_ext}, {1'b1, held_evt});
    evt_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    stalled = clrn && evt_valid && !evt_ready;
    held_evt = {evt_code, evt_break, evt_ext};
    if (clrn && evt_valid && evt_ready) begin
      n_evt++;
      if (exp_q.size() == 0) chk("unexpected_evt", {24'h0, evt_code}, 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("event", {evt_code, evt_break, evt_ext, key_down, cur_code, cur_ext, press_cnt},
            {e.code, e.brk, e.ext, e.down, e.cc, e.ce, e.cnt});
      end
    end
  end

  initial begin
    int p, ev, t;
    logic [7:0] c0;
    logic [7:0] pool [5];
    pool = '{8'h1C, 8'h1B, 8'h75, 8'hE0, 8'hF0};
    #2 clrn = 0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset_state");
    clrn = 1;
    rdy_mode = 0;
    p = pops;
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain();
    chk("t1_pops", pops - p, 3);
    chk("t1_key_down", {31'b0, key_down}, 0);
    chk("t1_press_cnt", {24'b0, press_cnt}, 1);
    c0 = m_cnt;
    ev = n_evt;
    send(8'h1B); send(8'h1B); send(8'h1B); send(8'hF0); send(8'h1B);
    drain();
    chk("t2_events", n_evt - ev, FILT ? 2 : 4);
    chk("t2_press_cnt", {24'b0, press_cnt}, {24'b0, c0 + (FILT ? 8'd1 : 8'd3)});
    chk("t2_key_down", {31'b0, key_down}, 0);
    send(8'hE0); send(8'h75);
    drain();
    chk("t3_held", {key_down, cur_ext, cur_code}, {1'b1, 1'b1, 8'h75});
    send(8'hE0); send(8'hF0); send(8'h75);
    drain();
    chk("t3_key_down", {31'b0, key_down}, 0);
    rdy_mode = 2;
    send(8'h1C); send(8'h2A);
    t = 0;
    while (!evt_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("t4_evt_seen", 32'(t < 100), 1);
    repeat (3) @(negedge clk);
    p = pops;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("t4_stall_code", {evt_valid, evt_code}, {1'b1, 8'h1C});
    end
    chk("t4_no_pop", pops - p, 0);
    rdy_mode = 0;
    drain();
    chk("t4_resume_pop", pops - p, 1);
    kbd_overflow = 1;
    @(negedge clk);
    kbd_overflow = 0;
    chk("t5_ovf_set", {31'b0, ovf_sticky}, 1);
    repeat (5) @(negedge clk);
    chk("t5_ovf_held", {31'b0, ovf_sticky}, 1);
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    chk("t5_ovf_clr", {31'b0, ovf_sticky}, 0);
    kbd_overflow = 1; ovf_clr = 1;
    @(negedge clk);
    kbd_overflow = 0; ovf_clr = 0;
    chk("t5_set_wins", {31'b0, ovf_sticky}, 1);
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    send(8'hF0);
    drain();
    clrn = 0;
    m_ext = 0; m_brk = 0; m_down = 0; m_ce = 0; m_cc = 0; m_cnt = 0;
    #1 chk_reset_vals("t6_in_reset0");
    @(negedge clk);
    chk_reset_vals("t6_in_reset1");
    @(negedge clk);
    clrn = 1;
    send(8'h1C);
    drain();
    chk("t6_after", {key_down, cur_code, press_cnt}, {1'b1, 8'h1C, 8'h01});
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      int k;
      k = $urandom_range(0, 7);
      send(k < 5 ? pool[k] : 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    chk("t7_all_consumed", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
- Sequences the ps2_keyboard receiver. Drains its FIFO through the ready/nextdata_n handshake.
- Decodes scan-code set 2 prefixes: F0 = break, E0 = extended.
- Emits one key event per complete code on a valid/ready port.
- Tracks the currently held key and a press counter. Sits between ps2_keyboard and display/consumer logic such as keyboard_display.

Parameters:
- BREAK_CODE, 8'hF0, prefix byte marking a key release.
- EXT_CODE, 8'hE0, prefix byte marking an extended key.
- CNT_W, 8, width of press_cnt.

Ports:
- clk  in  1  system clock, all logic on posedge.
- clrn  in  1  asynchronous active-low reset.
- kbd_data  in  8  byte at the head of the ps2_keyboard FIFO.
- kbd_ready  in  1  FIFO non-empty.
- kbd_overflow  in  1  FIFO overflow flag.
- kbd_nextdata_n  out  1  active-low pop strobe to ps2_keyboard.
- evt_valid  out  1  key event available.
- evt_ready  in  1  consumer accepts the event.
- evt_code  out  8  scan code of the event.
- evt_break  out  1  1 = release, 0 = press.
- evt_ext  out  1  event had the E0 prefix.
- key_down  out  1  a key is currently held.
- cur_code  out  8  code of the held key.
- cur_ext  out  1  ext flag of the held key.
- press_cnt  out  CNT_W  count of emitted press events.
- ovf_clr  in  1  synchronous clear of ovf_sticky.
- ovf_sticky  out  1  latched kbd_overflow.

Behaviour:
- Reset (clrn=0, async) forces:
  - FSM to IDLE.
  - kbd_nextdata_n=1.
  - evt_valid, evt_code, evt_break, evt_ext = 0.
  - key_down, cur_code, cur_ext = 0.
  - press_cnt=0, ovf_sticky=0.
  - Prefix flags cleared.
- FSM states: IDLE, POP, SETTLE.
  - IDLE → POP when kbd_ready=1 and the slot is free (evt_valid=0, or evt_valid&evt_ready this cycle). Byte is captured from kbd_data on this edge.
  - POP: kbd_nextdata_n=0 for exactly one cycle, then → SETTLE.
  - SETTLE: kbd_nextdata_n=1 for one cycle so the FIFO's ready/data can update, then → IDLE.
  - Net effect: at most one byte per 3 cycles, and never a double pop.
- Decode at the capture edge, in this order:
  - Byte == EXT_CODE: set ext_flag, no event.
  - Byte == BREAK_CODE: set brk_flag, no event.
  - Any other byte: form event {code=byte, break=brk_flag, ext=ext_flag}, then clear both flags.
  - E0 F0 xx yields ext=1, break=1. F0 E0 xx is accepted identically.
- Event port:
  - evt_valid rises 1 cycle after the capture edge.
  - evt_code/evt_break/evt_ext stay stable while evt_valid=1 and evt_ready=0.
  - Event is consumed on the edge where evt_valid&evt_ready.
  - Accept and a new capture on the same edge: the new event replaces the old one, so evt_valid stays 1.
- Held-key tracking, updated when an event is formed:
  - Press: key_down=1, cur_code=code, cur_ext=ext.
  - Break matching cur_code/cur_ext: key_down=0.
  - Break of any other code: held state unchanged.
- press_cnt increments on each emitted press event and wraps from 2^CNT_W-1 to 0.
- Overflow:
  - ovf_sticky is set while kbd_overflow=1 and cleared by ovf_clr.
  - If set and clear occur in the same cycle, set wins.
  - Decoding continues normally; there is no flush.
- Reset mid-sequence (e.g. after F0): prefix flags are lost, and the next byte decodes as a make.
- Consumer stall: the FSM stays in IDLE with no pop, and bytes accumulate in the ps2_keyboard FIFO. Any resulting overflow is reported only through ovf_sticky.

Optional Feature:
- PS2_KBD_REPEAT_FILTER_EN defined: a press whose code/ext equals cur_code/cur_ext while key_down=1 (typematic repeat) is dropped. It produces no event and no press_cnt increment, but the byte is still popped.
- Undefined: every make byte emits an event and increments press_cnt.

Decomposition:
- Package ps2_kbd_pkg holds:
  - FSM state enum (IDLE/POP/SETTLE).
  - Default BREAK_CODE and EXT_CODE constants.
  - A key event struct {code[7:0], brk, ext}.
- One natural sub-module, ps2_kbd_decode: combinational prefix/event formation plus the flag registers. It takes the captured byte and returns the event struct and a valid bit.
- Handshake FSM, event register and held-key state stay in the top module.

Test Plan:
- Bytes 1C, F0, 1C with evt_ready=1:
  - Events {1C,brk0,ext0} then {1C,brk1,ext0}.
  - key_down goes 1 then 0; press_cnt=1.
  - kbd_nextdata_n is low exactly 3 single cycles, each followed by ≥1 high cycle.
- Bytes 1B, 1B, 1B, F0, 1B:
  - With PS2_KBD_REPEAT_FILTER_EN: 2 events (press, release), press_cnt=1.
  - Without it: 4 events, press_cnt=3.
- Bytes E0, 75, E0, F0, 75:
  - Events {75,brk0,ext1} and {75,brk1,ext1}.
  - cur_ext=1 while held; key_down returns to 0.
- evt_ready=0 for 50 cycles with 1C queued:
  - evt_valid=1 and evt_code=1C stable throughout.
  - No further kbd_nextdata_n pulses.
  - Releasing evt_ready consumes the event and pops the next byte.
- Pulse kbd_overflow for 1 cycle:
  - ovf_sticky=1 and held until ovf_clr.
  - ovf_clr coincident with kbd_overflow=1 leaves ovf_sticky=1.
- Send F0, assert clrn=0 for 2 cycles, then send 1C:
  - All outputs at reset values during reset.
  - Then event {1C,brk0,ext0}, key_down=1.
